// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin / fixed-priority stream arbiter.
// Contents: selection-policy encodings and a helper for the burst counter width.
package arbiter_pkg;

  localparam bit ARB_FIXED = 1'b0;
  localparam bit ARB_RR    = 1'b1;

  // Width of a counter that must hold 0..max_hold (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// Stream bundle between N producers, the arbiter and one consumer.
// Signals: istream_val/rdy/msg per input, ostream_val/rdy/msg for the merged
// output ({source_index, payload}).
// Modports: master = the producer/consumer side, slave = the arbiter.
interface arbiter_rr_if #(
  parameter int unsigned nbits   = 32,
  parameter int unsigned ninputs = 4
);
  localparam int unsigned addr_nbits = $clog2(ninputs);

  logic [ninputs-1:0]          istream_val;
  logic [ninputs-1:0]          istream_rdy;
  logic [nbits-1:0]            istream_msg [ninputs];
  logic                        ostream_val;
  logic                        ostream_rdy;
  logic [addr_nbits+nbits-1:0] ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

endinterface

// File: rtl/arbiter_rr_select.sv
// Combinational requester search.
// Ports: valid (request vector), start (previous grant), mode (ARB_RR/ARB_FIXED)
//        -> sel (chosen index), any_valid (at least one request).
// Round-robin searches start+1, start+2, ... wrapping and ending at start;
// fixed mode picks the lowest valid index. With no request, sel = start.
module arbiter_rr_select
  import arbiter_pkg::*;
#(
  parameter int unsigned ninputs = 4,
  localparam int unsigned addr_nbits = $clog2(ninputs)
) (
  input  logic [ninputs-1:0]    valid,
  input  logic [addr_nbits-1:0] start,
  input  logic                  mode,
  output logic [addr_nbits-1:0] sel,
  output logic                  any_valid
);

  logic [addr_nbits-1:0] idx;

  // Loops run from the farthest candidate to the nearest so the last hit wins.
  always_comb begin
    sel       = start;
    idx       = '0;
    any_valid = |valid;
    if (mode == ARB_RR) begin
      for (int unsigned k = ninputs; k >= 1; k--) begin
        idx = addr_nbits'((32'(start) + k) % ninputs);
        if (valid[idx]) sel = idx;
      end
    end else begin
      for (int i = int'(ninputs) - 1; i >= 0; i--) begin
        idx = addr_nbits'(i);
        if (valid[idx]) sel = idx;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-input val/rdy arbiter merging request streams onto one output tagged with
// the source index, with bounded bursts and a 2-entry output skid buffer.
// Ports: clk, reset (async, active-low), bus (arbiter_rr_if.slave).
// istream_rdy depends only on registered occupancy and the current grant, so
// there is no combinational path from ostream_rdy to any istream_rdy.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned nbits    = 32,
  parameter int unsigned ninputs  = 4,
  parameter bit          rr_mode  = ARB_RR,
  parameter int unsigned max_hold = 8
) (
  input  logic         clk,
  input  logic         reset,
  arbiter_rr_if.slave  bus
);

  localparam int unsigned addr_nbits = $clog2(ninputs);
  localparam int unsigned cnt_nbits  = cnt_width(max_hold);
  localparam int unsigned word_nbits = addr_nbits + nbits;

  logic [addr_nbits-1:0] last_grant;
  logic [addr_nbits-1:0] cur_grant;
  logic [addr_nbits-1:0] sel;
  logic                  any_valid;
  logic [cnt_nbits-1:0]  hold_cnt;
  logic [cnt_nbits-1:0]  cnt_nxt;
  logic [word_nbits-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  hold_c;
  logic                  space_c;
  logic                  xfer_c;
  logic                  deq_c;

  arbiter_rr_select #(
    .ninputs (ninputs)
  ) u_select (
    .valid     (bus.istream_val),
    .start     (last_grant),
    .mode      (rr_mode),
    .sel       (sel),
    .any_valid (any_valid)
  );

  // Grant, readiness and burst-count bookkeeping.
  always_comb begin
    hold_c = bus.istream_val[last_grant] &&
             ((rr_mode == ARB_FIXED) || (max_hold == 0) || (32'(hold_cnt) < max_hold));

    cur_grant = last_grant;
    if (!hold_c && any_valid) cur_grant = sel;

    space_c = (occ != 2'd2) && reset;
    bus.istream_rdy = '0;
    if (space_c) bus.istream_rdy[cur_grant] = 1'b1;

    xfer_c = bus.istream_val[cur_grant] && space_c;
    deq_c  = (occ != 2'd0) && bus.ostream_rdy;

    // A failed hold starts a new burst that counts this cycle's transfer.
    cnt_nxt = hold_cnt;
    if (!hold_c) begin
      cnt_nxt = (xfer_c && (max_hold != 0)) ? cnt_nbits'(1) : '0;
    end else if (xfer_c && (32'(hold_cnt) < max_hold)) begin
      cnt_nxt = hold_cnt + cnt_nbits'(1);
    end
  end

  // Output view of the skid buffer head.
  always_comb begin
    bus.ostream_val = (occ != 2'd0);
    bus.ostream_msg = (occ != 2'd0) ? fifo_mem[rd_ptr] : '0;
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= '0;
      hold_cnt   <= '0;
      occ        <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      last_grant <= cur_grant;
      hold_cnt   <= cnt_nxt;
      if (xfer_c) wr_ptr <= ~wr_ptr;
      if (deq_c)  rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(xfer_c) - 2'(deq_c);
    end
  end

  // Payload storage; stale contents are masked by occupancy.
  always_ff @(posedge clk) begin
    if (xfer_c) fifo_mem[wr_ptr] <= {cur_grant, bus.istream_msg[cur_grant]};
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Scoreboard bench for arbiter_rr: one round-robin instance (max_hold=2) and
// one fixed-priority instance share the same stimulus.
module tb_arbiter_rr;
  import arbiter_pkg::*;

  localparam int unsigned NB = 16;
  localparam int unsigned NI = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned WW = AW + NB;

  logic          clk;
  logic          reset;
  logic [NI-1:0] val;
  logic [NB-1:0] msg [NI];
  logic          ordy;

  int checks = 0;
  int passes = 0;

  // model state per instance (0 = round-robin, 1 = fixed)
  int m_last [2];
  int m_cnt  [2];
  int m_occ  [2];
  logic [WW-1:0] q0 [$];
  logic [WW-1:0] q1 [$];
  int rr_src [8];
  int rec_n = 0;

  arbiter_rr_if #(.nbits(NB), .ninputs(NI)) if0 ();
  arbiter_rr_if #(.nbits(NB), .ninputs(NI)) if1 ();

  assign if0.istream_val = val;
  assign if0.istream_msg = msg;
  assign if0.ostream_rdy = ordy;
  assign if1.istream_val = val;
  assign if1.istream_msg = msg;
  assign if1.ostream_rdy = ordy;

  arbiter_rr #(.nbits(NB), .ninputs(NI), .rr_mode(ARB_RR), .max_hold(2)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  arbiter_rr #(.nbits(NB), .ninputs(NI), .rr_mode(ARB_FIXED), .max_hold(8)) u_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit vbit(input int i);
    return ((32'(val) >> i) & 32'd1) != 0;
  endfunction

  function automatic logic [NI-1:0] rdy_of(input int d);
    return (d == 0) ? if0.istream_rdy : if1.istream_rdy;
  endfunction

  function automatic logic oval_of(input int d);
    return (d == 0) ? if0.ostream_val : if1.ostream_val;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 0;
      m_cnt[d]  = 0;
      m_occ[d]  = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Reference step for one instance: evaluated mid-cycle, then advanced to the next edge.
  task automatic step(input int d);
    int  mh, g;
    bit  fixed_m, hold, xfer, deq;
    logic [NI-1:0] er;
    mh      = (d == 0) ? 2 : 8;
    fixed_m = (d == 1);
    hold    = vbit(m_last[d]) && (fixed_m || (mh == 0) || (m_cnt[d] < mh));
    g       = m_last[d];
    if (!hold && (val != '0)) begin
      if (fixed_m) begin
        for (int i = NI - 1; i >= 0; i--) if (vbit(i)) g = i;
      end else begin
        for (int k = NI; k >= 1; k--) if (vbit((m_last[d] + k) % NI)) g = (m_last[d] + k) % NI;
      end
    end
    er = '0;
    if (m_occ[d] < 2) er = NI'(1 << g);
    chk($sformatf("istream_rdy[d%0d]", d), 64'(rdy_of(d)), 64'(er));
    chk($sformatf("ostream_val[d%0d]", d), 64'(oval_of(d)), 64'(m_occ[d] != 0));
    xfer = vbit(g) && (m_occ[d] < 2);
    if (xfer) begin
      if (d == 0) q0.push_back({AW'(g), msg[AW'(g)]});
      else        q1.push_back({AW'(g), msg[AW'(g)]});
    end
    deq = (m_occ[d] != 0) && ordy;
    if (!hold) m_cnt[d] = xfer ? 1 : 0;
    else if (xfer && (m_cnt[d] < mh)) m_cnt[d]++;
    m_last[d] = g;
    m_occ[d]  = m_occ[d] + int'(xfer) - int'(deq);
  endtask

  task automatic rand_msgs();
    for (int i = 0; i < NI; i++) msg[i] = NB'($urandom);
  endtask

  // One clock: inputs already set; model at negedge, return just after posedge.
  task automatic cycle();
    @(negedge clk);
    step(0);
    step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NI-1:0] v, input bit r);
    val  = v;
    ordy = r;
    rand_msgs();
    cycle();
  endtask

  // Same as drive, plus a direct check of one instance's ready vector.
  task automatic drive_chk(input logic [NI-1:0] v, input bit r, input int d,
                           input string name, input logic [NI-1:0] exp_rdy);
    val  = v;
    ordy = r;
    rand_msgs();
    @(negedge clk);
    chk(name, 64'(rdy_of(d)), 64'(exp_rdy));
    step(0);
    step(1);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard whenever an instance hands off a word.
  always @(negedge clk) begin
    logic [WW-1:0] e;
    if (reset) begin
      if (if0.ostream_val && ordy) begin
        if (q0.size() == 0) begin
          checks++;
          $display("FAIL out_msg[d0]: got %0h, expected no output", if0.ostream_msg);
        end else begin
          e = q0.pop_front();
          chk("out_msg[d0]", 64'(if0.ostream_msg), 64'(e));
          if (rec_n < 8) begin
            rr_src[rec_n] = int'(if0.ostream_msg >> NB);
            rec_n++;
          end
        end
      end
      if (if1.ostream_val && ordy) begin
        if (q1.size() == 0) begin
          checks++;
          $display("FAIL out_msg[d1]: got %0h, expected no output", if1.ostream_msg);
        end else begin
          e = q1.pop_front();
          chk("out_msg[d1]", 64'(if1.ostream_msg), 64'(e));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) rr_src[i] = -1;
    reset = 1'b1;
    val   = '1;
    ordy  = 1'b1;
    rand_msgs();
    model_reset();
    #2 reset = 1'b0;

    // reset held with every input requesting
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy[d0]", 64'(if0.istream_rdy), 64'd0);
      chk("rst_rdy[d1]", 64'(if1.istream_rdy), 64'd0);
      chk("rst_oval[d0]", 64'(if0.ostream_val), 64'd0);
      chk("rst_omsg[d0]", 64'(if0.ostream_msg), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // round-robin bursts of two with all inputs requesting
    drive_chk('1, 1'b1, 0, "post_rst_rdy[d0]", 4'b0001);
    repeat (11) drive('1, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_seq[%0d]", i), 64'(rr_src[i]), 64'(i / 2));

    // fixed priority: 1 holds, 3 takes over, 3 keeps grant when 1 returns
    repeat (3) drive('0, 1'b1);
    drive_chk(4'b1010, 1'b1, 1, "fix_first[d1]", 4'b0010);
    repeat (5) drive_chk(4'b1010, 1'b1, 1, "fix_hold1[d1]", 4'b0010);
    drive_chk(4'b1000, 1'b1, 1, "fix_switch3[d1]", 4'b1000);
    repeat (2) drive(4'b1000, 1'b1);
    repeat (4) drive_chk(4'b1010, 1'b1, 1, "fix_keep3[d1]", 4'b1000);

    // backpressure: only two words absorbed while the consumer stalls
    repeat (3) drive('0, 1'b1);
    repeat (2) drive(4'b0100, 1'b0);
    repeat (3) drive_chk(4'b0100, 1'b0, 0, "bp_full[d0]", 4'b0000);
    repeat (4) drive(4'b0100, 1'b1);

    // sole requester keeps the grant across hold-limit renewals
    repeat (2) drive(4'b0010, 1'b1);
    repeat (10) drive_chk(4'b0010, 1'b1, 0, "sole_req[d0]", 4'b0010);

    // randomized traffic
    repeat (1500) drive(NI'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));

    // reset with a full buffer
    repeat (3) drive('1, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_oval[d0]", 64'(if0.ostream_val), 64'd0);
    chk("midrst_oval[d1]", 64'(if1.ostream_val), 64'd0);
    chk("midrst_rdy[d0]", 64'(if0.istream_rdy), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive_chk('1, 1'b1, 0, "midrst_rel_rdy[d0]", 4'b0001);
    repeat (200) drive(NI'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));

    // drain and confirm nothing is left outstanding
    repeat (4) drive('0, 1'b1);
    chk("drain_q[d0]", 64'(q0.size()), 64'd0);
    chk("drain_q[d1]", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
# arbiter_rr

Parametrised N-input val/rdy arbiter that merges several request streams onto one output stream tagged with the source index. It generalises the hold-while-valid arbiter with three features: round-robin or fixed-priority selection, a bounded burst length per grant, and a registered 2-entry output skid buffer that removes the combinational `ostream_rdy` → `istream_rdy` path. It sits between multiple producers, such as router ports or accelerator lanes, and a single shared consumer.

## Interface
- `nbits`, 32, payload width per input.
- `ninputs`, 4, number of input streams; must be ≥ 2.
- `rr_mode`, 1, selection policy: 1 = round-robin, 0 = fixed priority (lowest index wins).
- `max_hold`, 8, maximum consecutive accepted transfers per grant in round-robin mode; 0 = unlimited.
- `addr_nbits`, localparam, `$clog2(ninputs)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `istream_val[ninputs]`  in  1 each  input valid.
- `istream_rdy[ninputs]`  out  1 each  input ready.
- `istream_msg[ninputs]`  in  nbits each  input payload.
- `ostream_val`  out  1  output valid.
- `ostream_rdy`  in  1  output ready.
- `ostream_msg`  out  addr_nbits+nbits  output word `{source_index, payload}`.

## Operation
- **State:**
  - `last_grant` (addr_nbits).
  - `hold_cnt` ($clog2(max_hold+1) bits, minimum 1).
  - 2-entry FIFO of width addr_nbits+nbits, with an occupancy count of 0..2.
- **Hold condition:** `istream_val[last_grant]` is set, and either `rr_mode`=0, or `max_hold`=0, or `hold_cnt` < `max_hold`.
- **cur_grant (combinational):**
  - If the hold condition is true, cur_grant = last_grant.
  - Otherwise, in round-robin mode, cur_grant is the first valid index found by searching last_grant+1, last_grant+2, … with wrap modulo ninputs, ending at last_grant itself.
  - Otherwise, in fixed mode, cur_grant is the lowest valid index.
  - If no input is valid, cur_grant = last_grant.
- **Ready:** `istream_rdy[i]` = (i == cur_grant) && (occupancy < 2). Non-granted inputs always see 0.
- **Transfer:** a transfer occurs when `istream_val[cur_grant]` and `istream_rdy[cur_grant]` are both set. It enqueues `{cur_grant, istream_msg[cur_grant]}`.
- **Dequeue:** a dequeue occurs when `ostream_val` and `ostream_rdy` are both set.
  - Enqueue and dequeue in the same cycle is legal at every occupancy; occupancy is then unchanged.
- **Every edge:** `last_grant` ← cur_grant.
- **hold_cnt update, every edge:**
  - If the hold condition is false, the new burst starts at 0 and counts this cycle's transfer: hold_cnt ← transfer ? 1 : 0. This applies even if cur_grant == last_grant.
  - Otherwise, hold_cnt ← hold_cnt + transfer.
  - The counter saturates at `max_hold`.
- **Output:** `ostream_val` = (occupancy ≠ 0). `ostream_msg` = FIFO head, or 0 when the FIFO is empty.
- **Ordering:** output order equals acceptance order. No message is dropped or duplicated.

## Timing
- **Reset (asynchronous assert, synchronous release):**
  - last_grant = 0, hold_cnt = 0, FIFO empty.
  - `ostream_val` = 0, `ostream_msg` = 0.
  - `istream_rdy` is all zero while reset is asserted.
- **Reset mid-operation:** FIFO contents are discarded and the first cycle after release behaves as after power-up.
- **Latency:** a message accepted at edge t appears on `ostream_msg` in cycle t+1 if the FIFO was empty.
- **Throughput:** 1 message per cycle while `ostream_rdy` stays high.
- **Backpressure:**
  - After `ostream_rdy` drops, up to 2 further messages are absorbed; then all `istream_rdy` go low.
  - Inputs see ready again in the cycle after the first dequeue.
- **Grant switch:** takes effect in the same cycle the hold condition fails. There are no bubble cycles between bursts.
- **No combinational path** from `ostream_rdy` to any `istream_rdy`.

## Structure
- **Shared package `arbiter_pkg`:** `rr_mode` encoding constants `ARB_FIXED`=0 and `ARB_RR`=1.
- **Sub-module `arbiter_rr_select`:** purely combinational. Takes the valid vector, start index and mode, and returns the selected index plus an `any_valid` flag.
- **Top level:** holds the grant/count registers and the 2-entry FIFO inline.

## Test plan
- **Reset:** assert reset low with all inputs valid → `ostream_val`=0, all `istream_rdy`=0. After release, `istream_rdy[0]`=1 and the first output is `{0, msg0}` one cycle later.
- **Round-robin bound:** ninputs=4, max_hold=2, all inputs continuously valid, `ostream_rdy`=1 → output source sequence is 0,0,1,1,2,2,3,3,0,…
- **Fixed priority:** `rr_mode`=0 with inputs 1 and 3 valid → 1 holds indefinitely. When 1 drops, the grant moves to 3 in the same cycle. When 1 reasserts, 3 keeps the grant while it remains valid.
- **Backpressure:** `ostream_rdy`=0 for 5 cycles while input 2 streams A,B,C,… → exactly A,B are accepted and `istream_rdy[2]`=0 thereafter. After release, the output is A,B,C in order with no loss.
- **Sole requester exhausting hold:** max_hold=3, only input 1 valid for 8 transfers → the grant stays at 1 and throughput stays 1 per cycle. `hold_cnt` cycles 1,2,3,1,2,3,…
- **Mid-operation reset:** reset asserted with FIFO occupancy 2 → both entries lost. `ostream_val`=0 immediately, asynchronously, without waiting for a clock edge.
